// File: rtl/bin_a_bcd_secuencial.sv
// Sequential binary-to-BCD converter (double dabble, one add-3/shift step
// per clock) feeding the display digit selector. The registered digit
// array only changes when a conversion completes, so the display never
// sees intermediate shift states.

package digito_pkg;
    // One BCD digit, 0..9 when valid.
    typedef logic [3:0] BCDnumber_t;
endpackage

// Handshake: in_start is a request that is accepted only on a cycle where
// out_busy is low (FSM in IDLE); in_bin is sampled on that same edge only.
// Requests while out_busy is high are dropped, never queued. out_done is a
// one-cycle pulse coinciding with the first cycle out_num/out_overflow
// hold the new result; the FSM is already IDLE then, so a request in the
// out_done cycle starts the next conversion immediately.
module bin_a_bcd_secuencial #(
    parameter int NRO_DIGITOS = 4,
    parameter int BIN_W       = 14
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [BIN_W-1:0]                         in_bin,
    input  logic                                     in_start,
    output digito_pkg::BCDnumber_t [NRO_DIGITOS-1:0] out_num,
    output logic                                     out_busy,
    output logic                                     out_done,
    output logic                                     out_overflow
);

    localparam int BCD_W = 4 * NRO_DIGITOS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    // Largest value representable with NRO_DIGITOS decimal digits.
    function automatic longint unsigned max_decimal(input int digits);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < digits; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

    localparam longint unsigned MAX_VALUE = max_decimal(NRO_DIGITOS);

    // The scratch register must be able to hold every input bit after the
    // last shift; a wider input cannot be converted by this structure.
    if (BIN_W > 4 * NRO_DIGITOS) begin : g_bin_w_too_wide
        $error("bin_a_bcd_secuencial: BIN_W (%0d) exceeds 4*NRO_DIGITOS (%0d)",
               BIN_W, 4 * NRO_DIGITOS);
    end
    if (BIN_W < 4) begin : g_bin_w_too_narrow
        $error("bin_a_bcd_secuencial: BIN_W (%0d) below minimum of 4", BIN_W);
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    // Current FSM state; kept as a plainly named signal so it can be probed.
    state_t             state;
    state_t             state_next;

    logic [BIN_W-1:0]   bin_reg;
    logic [BIN_W-1:0]   bin_next;
    logic [BCD_W-1:0]   scratch;
    logic [BCD_W-1:0]   scratch_next;
    logic [BCD_W-1:0]   adjusted;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic               ovf_flag;
    logic               ovf_next;
    logic [BCD_W-1:0]   num_reg;
    logic [BCD_W-1:0]   num_next;
    logic               ovf_out;
    logic               ovf_out_next;
    logic               done_reg;
    logic               done_next;
    logic               busy_reg;
    logic               busy_next;

    // Add-3 adjust: every nibble >= 5 gets +3 before the shift. A valid
    // nibble is <= 9 here, so the 4-bit sum never needs a carry out.
    always_comb begin
        adjusted = scratch;
        for (int i = 0; i < NRO_DIGITOS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    // Next-state and next-output logic; every target holds by default.
    always_comb begin
        state_next   = state;
        bin_next     = bin_reg;
        scratch_next = scratch;
        count_next   = count;
        ovf_next     = ovf_flag;
        num_next     = num_reg;
        ovf_out_next = ovf_out;
        done_next    = 1'b0;
        busy_next    = busy_reg;

        case (state)
            IDLE: begin
                if (in_start) begin
                    bin_next     = in_bin;
                    scratch_next = '0;
                    count_next   = CNT_W'(BIN_W);
                    ovf_next     = (64'(in_bin) > MAX_VALUE);
                    busy_next    = 1'b1;
                    state_next   = SHIFT;
                end
            end

            SHIFT: begin
                // Binary MSB enters scratch bit 0; scratch MSB falls off.
                {scratch_next, bin_next} = {adjusted, bin_reg} << 1;
                count_next = count - CNT_W'(1);
                if (count == CNT_W'(1)) begin
                    state_next = LOAD;
                end
            end

            LOAD: begin
                // Out-of-range inputs saturate the display to all nines.
                num_next     = ovf_flag ? {NRO_DIGITOS{4'h9}} : scratch;
                ovf_out_next = ovf_flag;
                done_next    = 1'b1;
                busy_next    = 1'b0;
                state_next   = IDLE;
            end

            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bin_reg  <= '0;
            scratch  <= '0;
            count    <= '0;
            ovf_flag <= 1'b0;
            num_reg  <= '0;
            ovf_out  <= 1'b0;
            done_reg <= 1'b0;
            busy_reg <= 1'b0;
        end else begin
            state    <= state_next;
            bin_reg  <= bin_next;
            scratch  <= scratch_next;
            count    <= count_next;
            ovf_flag <= ovf_next;
            num_reg  <= num_next;
            ovf_out  <= ovf_out_next;
            done_reg <= done_next;
            busy_reg <= busy_next;
        end
    end

    assign out_num      = num_reg;
    assign out_overflow = ovf_out;
    assign out_done     = done_reg;
    assign out_busy     = busy_reg;

endmodule

// File: tb/tb_bin_a_bcd_secuencial.sv
// Bench for bin_a_bcd_secuencial: directed scenarios with exact cycle
// timing, then randomized conversions scored against a decimal model.
module tb_bin_a_bcd_secuencial;
    import digito_pkg::*;

    localparam int ND  = 4;
    localparam int BW  = 14;
    localparam int LAT = BW + 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [BW-1:0]         in_bin;
    logic                  in_start;
    BCDnumber_t [ND-1:0]   out_num;
    logic                  out_busy;
    logic                  out_done;
    logic                  out_overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [16:0] exp_q[$];
    int          start_q[$];
    bit          sb_on = 1'b0;
    logic [16:0] sb_exp;
    int          sb_start;

    bin_a_bcd_secuencial #(.NRO_DIGITOS(ND), .BIN_W(BW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_bin       (in_bin),
        .in_start     (in_start),
        .out_num      (out_num),
        .out_busy     (out_busy),
        .out_done     (out_done),
        .out_overflow (out_overflow)
    );

    // Clock and cycle counter (cyc = number of rising edges so far).
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: decimal digits by division, saturated to 9999 with flag.
    function automatic logic [16:0] model(input int v);
        int          d;
        logic [15:0] digits;
        d = v;
        digits = '0;
        if (v > 9999) return {1'b1, 16'h9999};
        for (int i = 0; i < ND; i++) begin
            digits[4*i +: 4] = 4'(d % 10);
            d = d / 10;
        end
        return {1'b0, digits};
    endfunction

    function automatic logic [16:0] observed();
        return {out_overflow, out_num};
    endfunction

    // Called at a falling edge; returns at the falling edge after the start edge.
    task automatic start_pulse(input int v, output int k);
        in_bin   = BW'(v);
        in_start = 1'b1;
        @(negedge clk);
        in_start = 1'b0;
        k = cyc;
    endtask

    task automatic conv_directed(input int v, input string tag);
        int k;
        int early;
        early = 0;
        start_pulse(v, k);
        check({tag, "_busy_start"}, 32'(out_busy), 32'd1);
        for (int i = 1; i < LAT; i++) begin
            @(negedge clk);
            if (out_done) early++;
        end
        check({tag, "_early_done"}, 32'(early), 32'd0);
        @(negedge clk);
        check({tag, "_done_cycle"}, 32'(cyc - k), 32'(LAT));
        check({tag, "_done"}, 32'(out_done), 32'd1);
        check({tag, "_busy_end"}, 32'(out_busy), 32'd0);
        check({tag, "_data"}, 32'(observed()), 32'(model(v)));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(out_done), 32'd0);
    endtask

    // Scoreboard: every out_done must match the oldest accepted request.
    always @(negedge clk) begin
        if (sb_on && !rst && out_done) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                sb_exp   = exp_q.pop_front();
                sb_start = start_q.pop_front();
                check("sb_data", 32'(observed()), 32'(sb_exp));
                check("sb_latency", 32'(cyc - sb_start), 32'(LAT));
            end
        end
    end

    initial begin
        int k;
        int cnt_a;
        int cnt_b;
        int v;
        int waited;

        rst      = 1'b1;
        in_start = 1'b0;
        in_bin   = '0;

        // Reset values
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_num", 32'(out_num), 32'd0);
        check("rst_busy", 32'(out_busy), 32'd0);
        check("rst_done", 32'(out_done), 32'd0);
        check("rst_ovf", 32'(out_overflow), 32'd0);
        cnt_a = 0;
        in_bin = 14'd777;
        repeat (5) begin
            @(negedge clk);
            if (out_busy || out_done || out_num != '0) cnt_a++;
        end
        check("idle_activity", 32'(cnt_a), 32'd0);

        // Normal conversion and boundaries
        conv_directed(1234, "norm_1234");
        conv_directed(0, "bnd_0");
        conv_directed(9999, "bnd_9999");
        conv_directed(10000, "bnd_10000");
        conv_directed(16383, "bnd_max");

        // Start while busy is ignored
        cnt_a = 0;
        start_pulse(57, k);
        for (int i = 1; i < LAT; i++) begin
            @(negedge clk);
            if (out_done) cnt_a++;
            if (i == 4) begin
                in_bin   = 14'd800;
                in_start = 1'b1;
            end
            if (i == 5) in_start = 1'b0;
        end
        check("busy_start_early", 32'(cnt_a), 32'd0);
        @(negedge clk);
        check("busy_start_done", 32'(out_done), 32'd1);
        check("busy_start_data", 32'(observed()), 32'(model(57)));
        cnt_a = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_done || out_busy) cnt_a++;
        end
        check("busy_start_no_second", 32'(cnt_a), 32'd0);

        // Back-to-back with in_start held high
        in_bin   = 14'd42;
        in_start = 1'b1;
        @(negedge clk);
        k = cyc;
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 1; i <= 2 * LAT + 1; i++) begin
            @(negedge clk);
            if (out_busy !== !(i == LAT || i == 2 * LAT + 1)) cnt_a++;
            if (out_done && !(i == LAT || i == 2 * LAT + 1)) cnt_b++;
            if (i == LAT) begin
                check("b2b_first_done", 32'(out_done), 32'd1);
                check("b2b_first_data", 32'(observed()), 32'(model(42)));
                in_bin = 14'd9000;
            end
            if (i == 2 * LAT + 1) begin
                check("b2b_second_done", 32'(out_done), 32'd1);
                check("b2b_second_data", 32'(observed()), 32'(model(9000)));
                in_start = 1'b0;
            end
        end
        check("b2b_busy_profile", 32'(cnt_a), 32'd0);
        check("b2b_stray_done", 32'(cnt_b), 32'd0);
        repeat (LAT + 2) @(negedge clk);

        // Reset mid-conversion
        start_pulse(4321, k);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 6) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        check("midrst_num", 32'(out_num), 32'd0);
        check("midrst_busy", 32'(out_busy), 32'd0);
        check("midrst_done", 32'(out_done), 32'd0);
        check("midrst_ovf", 32'(out_overflow), 32'd0);
        cnt_a = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_done || out_busy || out_num != '0) cnt_a++;
        end
        check("midrst_quiet", 32'(cnt_a), 32'd0);

        // Randomized conversions with noise on the inputs while busy
        sb_on = 1'b1;
        for (int t = 0; t < 40; t++) begin
            waited = 0;
            while (out_busy && waited < 40) begin
                @(negedge clk);
                waited++;
            end
            if (out_busy) check("rand_busy_timeout", 32'd1, 32'd0);
            if ($urandom_range(0, 3) == 0) v = int'($urandom_range(9990, 10010));
            else v = int'($urandom_range(0, 16383));
            in_bin   = BW'(v);
            in_start = 1'b1;
            exp_q.push_back(model(v));
            start_q.push_back(cyc + 1);
            @(negedge clk);
            in_start = 1'b0;
            repeat ($urandom_range(1, 18)) begin
                in_bin   = BW'($urandom_range(0, 16383));
                in_start = out_busy && ($urandom_range(0, 3) == 0);
                @(negedge clk);
            end
            in_start = 1'b0;
        end
        waited = 0;
        while (exp_q.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        sb_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
